execute_pipe: RTL and testbench

- Parametrised next-generation execute stage for the uRISC pipeline. Sits between decode and memory, and owns the EX/MEM pipeline register.
- Adds over the previous stage:
  - valid/ready handshakes on input and output
  - operand forwarding from EX/MEM and MEM/WB
  - load-use stall detection
  - an iterative multi-cycle multiplier
  - a registered one-cycle branch/jump redirect with a wrong-path squash
- Operand values come from the external register file; this block holds no register file.

---
 rtl/exec_pkg.sv | 53 +++++
 rtl/execute_pipe_if.sv | 58 +++++
 rtl/mul_iter.sv | 48 ++++
 rtl/execute_pipe.sv | 191 +++++++++++++++++++
 tb/tb_execute_pipe.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcode enum, multiplier FSM states
// and small opcode classification helpers.
package exec_pkg;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_XOR  = 5'd3,
      OP_SLL  = 5'd4,
      OP_SRL  = 5'd5,
      OP_ROL  = 5'd6,
      OP_ROR  = 5'd7,
      OP_SLT  = 5'd8,
      OP_SEQ  = 5'd9,
      OP_LD   = 5'd10,
      OP_ST   = 5'd11,
      OP_BEQZ = 5'd12,
      OP_BNEZ = 5'd13,
      OP_BLTZ = 5'd14,
      OP_BGEZ = 5'd15,
      OP_J    = 5'd16,
      OP_JR   = 5'd17,
      OP_JAL  = 5'd18,
      OP_JALR = 5'd19,
      OP_MUL  = 5'd20
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // Ops whose B operand comes from rt when in_use_imm is clear.
   function automatic logic op_uses_b(input op_e op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_ROL, OP_ROR,
         OP_SLT, OP_SEQ, OP_MUL: op_uses_b = 1'b1;
         default:                op_uses_b = 1'b0;
      endcase
   endfunction

   function automatic logic is_branch(input op_e op);
      is_branch = (op == OP_BEQZ) || (op == OP_BNEZ) ||
                  (op == OP_BLTZ) || (op == OP_BGEZ);
   endfunction

   function automatic logic is_jump(input op_e op);
      is_jump = (op == OP_J) || (op == OP_JR) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-side, write-back and EX/MEM-side signals of the execute stage.
// The slave modport is the execute stage itself.
interface execute_pipe_if #(
   parameter int XLEN = 16,
   parameter int NREG = 8
);
   import exec_pkg::*;

   localparam int REGW = $clog2(NREG);

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   op_e             in_op;
   logic [REGW-1:0] in_rs_idx;
   logic [REGW-1:0] in_rt_idx;
   logic [XLEN-1:0] in_rs_val;
   logic [XLEN-1:0] in_rt_val;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic [REGW-1:0] in_dest_idx;
   logic            in_dest_we;

   logic            wb_valid;
   logic [REGW-1:0] wb_idx;
   logic [XLEN-1:0] wb_val;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [REGW-1:0] out_dest_idx;
   logic            out_dest_we;
   logic            out_is_load;
   logic            out_is_store;
   logic [XLEN-1:0] out_store_data;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;

   modport master (
      output in_valid, in_pc, in_op, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
             in_imm, in_use_imm, in_dest_idx, in_dest_we,
             wb_valid, wb_idx, wb_val, out_ready,
      input  in_ready, out_valid, out_result, out_dest_idx, out_dest_we,
             out_is_load, out_is_store, out_store_data,
             redirect_valid, redirect_target
   );

   modport slave (
      input  in_valid, in_pc, in_op, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
             in_imm, in_use_imm, in_dest_idx, in_dest_we,
             wb_valid, wb_idx, wb_val, out_ready,
      output in_ready, out_valid, out_result, out_dest_idx, out_dest_we,
             out_is_load, out_is_store, out_store_data,
             redirect_valid, redirect_target
   );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN steps.
// done flags the cycle whose clock edge retires the final step.
module mul_iter #(
   parameter int XLEN = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] product
);

   localparam int CW = $clog2(XLEN);

   logic [CW-1:0]   count;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         count  <= CW'(XLEN - 1);
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (count == '0) busy <= 1'b0;
         else             count <= count - 1'b1;
      end
   end

   assign done    = busy && (count == '0);
   assign product = acc;

endmodule

// File: rtl/execute_pipe.sv
// uRISC execute stage: forwarding, load-use stall, iterative MUL,
// one-cycle branch/jump redirect, and the EX/MEM pipeline register.
module execute_pipe
   import exec_pkg::*;
#(
   parameter int XLEN   = 16,
   parameter int NREG   = 8,
   parameter int MUL_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   execute_pipe_if.slave bus
);

   localparam int REGW = $clog2(NREG);
   localparam int SHW  = $clog2(XLEN);
   localparam bit HAS_MUL = (MUL_EN != 0);

   fsm_e state, state_next;

   logic [XLEN-1:0] op_a, op_b, rt_fwd;
   logic [XLEN-1:0] alu_res, target, pc2;
   logic [2*XLEN-1:0] rot_t;
   logic [SHW-1:0]  sh;
   logic            taken;
   logic            rt_used, hazard, accept, slot_free;
   logic            is_mul_multi, start_mul, mul_load;
   logic            mul_busy, mul_done;
   logic [XLEN-1:0] mul_product;
   logic [REGW-1:0] mul_dest_idx;
   logic            mul_dest_we;

   // Youngest producer wins: EX/MEM (non-load), then the WB port, then the register file.
   function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] idx,
                                           input logic [XLEN-1:0] rf_val);
      if (bus.out_valid && bus.out_dest_we && !bus.out_is_load && bus.out_dest_idx == idx)
         fwd = bus.out_result;
      else if (bus.wb_valid && bus.wb_idx == idx)
         fwd = bus.wb_val;
      else
         fwd = rf_val;
   endfunction

   always_comb begin
      op_a    = fwd(bus.in_rs_idx, bus.in_rs_val);
      rt_fwd  = fwd(bus.in_rt_idx, bus.in_rt_val);
      op_b    = bus.in_use_imm ? bus.in_imm : rt_fwd;
      rt_used = (bus.in_op == OP_ST) || (!bus.in_use_imm && op_uses_b(bus.in_op));
      hazard  = bus.out_valid && bus.out_is_load && bus.out_dest_we &&
                ((bus.out_dest_idx == bus.in_rs_idx) ||
                 (rt_used && bus.out_dest_idx == bus.in_rt_idx));
   end

   assign slot_free    = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = !rst && (state == IDLE) && slot_free && !hazard && !bus.redirect_valid;
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_mul_multi = HAS_MUL && (bus.in_op == OP_MUL);
   assign start_mul    = accept && is_mul_multi;

   always_comb begin
      pc2     = bus.in_pc + XLEN'(2);
      target  = pc2 + bus.in_imm;
      sh      = op_b[SHW-1:0];
      rot_t   = '0;
      taken   = 1'b0;
      alu_res = op_a + op_b;
      case (bus.in_op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << sh;
         OP_SRL:  alu_res = op_a >> sh;
         OP_ROL: begin
            rot_t   = {op_a, op_a} << sh;
            alu_res = rot_t[2*XLEN-1:XLEN];
         end
         OP_ROR: begin
            rot_t   = {op_a, op_a} >> sh;
            alu_res = rot_t[XLEN-1:0];
         end
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SEQ:  alu_res = {{(XLEN-1){1'b0}}, (op_a == op_b)};
         OP_LD, OP_ST: alu_res = op_a + bus.in_imm;
         OP_BEQZ: begin taken = (op_a == '0);   alu_res = target; end
         OP_BNEZ: begin taken = (op_a != '0);   alu_res = target; end
         OP_BLTZ: begin taken = op_a[XLEN-1];   alu_res = target; end
         OP_BGEZ: begin taken = !op_a[XLEN-1];  alu_res = target; end
         OP_J:    begin taken = 1'b1;           alu_res = target; end
         OP_JR: begin
            taken   = 1'b1;
            target  = op_a + bus.in_imm;
            alu_res = target;
         end
         OP_JAL:  begin taken = 1'b1;           alu_res = pc2; end
         OP_JALR: begin
            taken   = 1'b1;
            target  = op_a + bus.in_imm;
            alu_res = pc2;
         end
         default: alu_res = op_a + op_b;
      endcase
   end

   mul_iter #(.XLEN(XLEN)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (start_mul),
      .a       (op_a),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_mul) state_next = BUSY;
         BUSY: begin
            if (mul_done)       state_next = DONE;
            else if (!mul_busy) state_next = IDLE;
         end
         DONE: if (slot_free) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mul_load = (state == DONE) && slot_free;
   end

   // MUL destination is captured at acceptance since decode moves on meanwhile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_dest_idx <= '0;
         mul_dest_we  <= 1'b0;
      end else if (start_mul) begin
         mul_dest_idx <= bus.in_dest_idx;
         mul_dest_we  <= bus.in_dest_we;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid      <= 1'b0;
         bus.out_result     <= '0;
         bus.out_dest_idx   <= '0;
         bus.out_dest_we    <= 1'b0;
         bus.out_is_load    <= 1'b0;
         bus.out_is_store   <= 1'b0;
         bus.out_store_data <= '0;
      end else if (accept && !is_mul_multi) begin
         bus.out_valid      <= 1'b1;
         bus.out_result     <= alu_res;
         bus.out_dest_idx   <= bus.in_dest_idx;
         bus.out_dest_we    <= bus.in_dest_we && !is_branch(bus.in_op) &&
                               (bus.in_op != OP_J) && (bus.in_op != OP_JR);
         bus.out_is_load    <= (bus.in_op == OP_LD);
         bus.out_is_store   <= (bus.in_op == OP_ST);
         bus.out_store_data <= rt_fwd;
      end else if (mul_load) begin
         bus.out_valid      <= 1'b1;
         bus.out_result     <= mul_product;
         bus.out_dest_idx   <= mul_dest_idx;
         bus.out_dest_we    <= mul_dest_we;
         bus.out_is_load    <= 1'b0;
         bus.out_is_store   <= 1'b0;
         bus.out_store_data <= '0;
      end else if (bus.out_ready) begin
         bus.out_valid      <= 1'b0;
      end
   end

   // The redirect pulse itself blocks in_ready, so it can never last two cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.redirect_valid  <= 1'b0;
         bus.redirect_target <= '0;
      end else begin
         bus.redirect_valid <= accept && taken;
         if (accept && taken) bus.redirect_target <= target;
      end
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe (XLEN=16, NREG=8, MUL_EN=1) with
// hand-computed expectations checked by immediate assertions.
module tb_execute_pipe;
   import exec_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   n;

   op_e         alu_ops [9] = '{OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_ROL, OP_ROR, OP_SLT, OP_SEQ};
   logic [15:0] alu_a   [9] = '{16'h0005, 16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000, 16'h8001, 16'h8001, 16'hFFFF, 16'h1234};
   logic [15:0] alu_b   [9] = '{16'h0007, 16'h0FF0, 16'h0FF0, 16'h0014, 16'h000F, 16'h0001, 16'h0004, 16'h0001, 16'h1234};
   logic [15:0] alu_exp [9] = '{16'hFFFE, 16'h00F0, 16'hFF00, 16'h0010, 16'h0001, 16'h0003, 16'h1800, 16'h0001, 16'h0001};

   execute_pipe_if #(.XLEN(16), .NREG(8)) bus ();

   execute_pipe #(.XLEN(16), .NREG(8), .MUL_EN(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input op_e op, input logic [2:0] rs, input logic [2:0] rt,
                                input logic [15:0] rs_val, input logic [15:0] rt_val,
                                input logic [15:0] imm, input logic use_imm,
                                input logic [2:0] dest, input logic dest_we, input logic [15:0] pc);
      bus.in_valid    = 1'b1;
      bus.in_op       = op;
      bus.in_rs_idx   = rs;
      bus.in_rt_idx   = rt;
      bus.in_rs_val   = rs_val;
      bus.in_rt_val   = rt_val;
      bus.in_imm      = imm;
      bus.in_use_imm  = use_imm;
      bus.in_dest_idx = dest;
      bus.in_dest_we  = dest_we;
      bus.in_pc       = pc;
   endtask

   task automatic waitMulDone();
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_op = OP_ADD;
      bus.in_rs_idx = '0;
      bus.in_rt_idx = '0;
      bus.in_rs_val = '0;
      bus.in_rt_val = '0;
      bus.in_imm = '0;
      bus.in_use_imm = 1'b0;
      bus.in_dest_idx = '0;
      bus.in_dest_we = 1'b0;
      bus.in_pc = '0;
      bus.wb_valid = 1'b0;
      bus.wb_idx = '0;
      bus.wb_val = '0;
      bus.out_ready = 1'b1;

      // reset state
      #2 rst = 1'b1;
      tick();
      tick();
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_result", bus.out_result, 0);
      checkOutput("rst_redirect", bus.redirect_valid, 0);
      checkOutput("rst_in_ready", bus.in_ready, 0);
      rst = 1'b0;
      #1 checkOutput("idle_in_ready", bus.in_ready, 1);

      // ADD R1=3, then R2=R1+R1 through EX/MEM forwarding
      applyStimulus(OP_ADD, 0, 0, 16'h0001, 16'h0000, 16'h0002, 1, 1, 1, 16'h0000);
      tick();
      checkOutput("add1_result", bus.out_result, 16'h0003);
      checkOutput("add1_valid", bus.out_valid, 1);
      applyStimulus(OP_ADD, 1, 1, 16'h0055, 16'h0055, 16'h0000, 0, 2, 1, 16'h0002);
      #1 checkOutput("fwd_no_stall", bus.in_ready, 1);
      tick();
      checkOutput("fwd_exmem_result", bus.out_result, 16'h0006);
      checkOutput("fwd_exmem_dest", bus.out_dest_idx, 2);

      // load-use stall then WB forwarding
      applyStimulus(OP_LD, 0, 0, 16'h000C, 16'h0000, 16'h0004, 1, 3, 1, 16'h0004);
      tick();
      checkOutput("ld_addr", bus.out_result, 16'h0010);
      checkOutput("ld_is_load", bus.out_is_load, 1);
      applyStimulus(OP_ADD, 3, 0, 16'h9999, 16'h0000, 16'h0001, 1, 4, 1, 16'h0006);
      #1 checkOutput("load_use_stall", bus.in_ready, 0);
      tick();
      checkOutput("stall_bubble", bus.out_valid, 0);
      bus.wb_valid = 1'b1;
      bus.wb_idx = 3'd3;
      bus.wb_val = 16'h00FF;
      #1 checkOutput("stall_release", bus.in_ready, 1);
      tick();
      checkOutput("wb_fwd_result", bus.out_result, 16'h0100);

      // EX/MEM beats WB on the same index
      bus.wb_idx = 3'd4;
      bus.wb_val = 16'h7777;
      applyStimulus(OP_ADD, 4, 4, 16'h0000, 16'h0000, 16'h0000, 0, 5, 1, 16'h0008);
      tick();
      bus.wb_valid = 1'b0;
      checkOutput("exmem_over_wb", bus.out_result, 16'h0200);

      // multiplier
      applyStimulus(OP_MUL, 1, 2, 16'h0123, 16'h0010, 16'h0000, 0, 6, 1, 16'h000A);
      #1 checkOutput("mul1_accept", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      checkOutput("mul1_busy_empty", bus.out_valid, 0);
      waitMulDone();
      checkOutput("mul1_latency", n, 17);
      checkOutput("mul1_valid", bus.out_valid, 1);
      checkOutput("mul1_result", bus.out_result, 16'h1230);
      checkOutput("mul1_dest", bus.out_dest_idx, 6);
      applyStimulus(OP_MUL, 1, 2, 16'hFFFF, 16'h0002, 16'h0000, 0, 6, 1, 16'h000C);
      tick();
      bus.in_valid = 1'b0;
      waitMulDone();
      checkOutput("mul2_latency", n, 17);
      checkOutput("mul2_result", bus.out_result, 16'hFFFE);

      // taken branch, wrong-path squash, JAL, not-taken branch
      applyStimulus(OP_BEQZ, 7, 0, 16'h0000, 16'h0000, 16'h0004, 1, 0, 0, 16'h0020);
      #1 checkOutput("beqz_accept", bus.in_ready, 1);
      tick();
      checkOutput("beqz_redirect", bus.redirect_valid, 1);
      checkOutput("beqz_target", bus.redirect_target, 16'h0026);
      checkOutput("beqz_dest_we", bus.out_dest_we, 0);
      applyStimulus(OP_ADD, 0, 0, 16'h0001, 16'h0000, 16'h0001, 1, 1, 1, 16'h0022);
      #1 checkOutput("redirect_blocks_ready", bus.in_ready, 0);
      tick();
      checkOutput("redirect_one_cycle", bus.redirect_valid, 0);
      checkOutput("wrong_path_squashed", bus.out_valid, 0);
      applyStimulus(OP_JAL, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 7, 1, 16'h0020);
      tick();
      checkOutput("jal_redirect", bus.redirect_valid, 1);
      checkOutput("jal_target", bus.redirect_target, 16'h0032);
      checkOutput("jal_link", bus.out_result, 16'h0022);
      checkOutput("jal_dest_we", bus.out_dest_we, 1);
      applyStimulus(OP_BLTZ, 5, 0, 16'h0005, 16'h0000, 16'h0000, 1, 0, 0, 16'h0040);
      #1 checkOutput("jal_blocks_ready", bus.in_ready, 0);
      tick();
      tick();
      checkOutput("bltz_not_taken", bus.redirect_valid, 0);
      checkOutput("bltz_entry_valid", bus.out_valid, 1);
      checkOutput("bltz_entry_result", bus.out_result, 16'h0042);

      // back-pressure hold then same-cycle reload
      applyStimulus(OP_ADD, 0, 0, 16'h0010, 16'h0000, 16'h0020, 1, 1, 1, 16'h0000);
      tick();
      bus.out_ready = 1'b0;
      checkOutput("hold_first", bus.out_result, 16'h0030);
      applyStimulus(OP_ADD, 0, 0, 16'h0001, 16'h0000, 16'h0001, 1, 2, 1, 16'h0002);
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("hold_ready_%0d", i), bus.in_ready, 0);
         checkOutput($sformatf("hold_result_%0d", i), bus.out_result, 16'h0030);
         checkOutput($sformatf("hold_valid_%0d", i), bus.out_valid, 1);
         tick();
      end
      bus.out_ready = 1'b1;
      #1 checkOutput("release_ready", bus.in_ready, 1);
      tick();
      checkOutput("reload_no_bubble_valid", bus.out_valid, 1);
      checkOutput("reload_no_bubble_result", bus.out_result, 16'h0002);

      // single-cycle ALU ops, pipelined back to back
      for (int i = 0; i < 9; i++) begin
         applyStimulus(alu_ops[i], 4, 5, alu_a[i], alu_b[i], 16'h0000, 0, 0, 0, 16'h0000);
         tick();
         checkOutput($sformatf("alu_%s", alu_ops[i].name()), bus.out_result, alu_exp[i]);
      end

      // reset in the middle of a multiply
      applyStimulus(OP_MUL, 1, 2, 16'h0003, 16'h0005, 16'h0000, 0, 6, 1, 16'h0000);
      tick();
      bus.in_valid = 1'b0;
      repeat (8) tick();
      rst = 1'b1;
      #1;
      checkOutput("midmul_rst_valid", bus.out_valid, 0);
      checkOutput("midmul_rst_result", bus.out_result, 0);
      checkOutput("midmul_rst_ready", bus.in_ready, 0);
      checkOutput("midmul_rst_target", bus.redirect_target, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 checkOutput("post_rst_ready", bus.in_ready, 1);
      applyStimulus(OP_ADD, 0, 0, 16'h0007, 16'h0000, 16'h0008, 1, 3, 1, 16'h0000);
      tick();
      checkOutput("post_rst_add", bus.out_result, 16'h000F);
      checkOutput("post_rst_valid", bus.out_valid, 1);
      applyStimulus(OP_ST, 0, 3, 16'h0100, 16'h00AB, 16'h0004, 1, 0, 0, 16'h0002);
      tick();
      checkOutput("st_addr", bus.out_result, 16'h0104);
      checkOutput("st_is_store", bus.out_is_store, 1);
      checkOutput("st_data_fwd", bus.out_store_data, 16'h000F);
      bus.in_valid = 1'b0;
      repeat (20) tick();
      checkOutput("no_stray_mul", bus.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
